// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master modport is the loader; the slave modport is the host link plus memory.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output we,
        output wa,
        output wd
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  we,
        input  wa,
        input  wd
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length/data/checksum byte frame,
// writes assembled 32-bit words to memory and releases the CPU once the image is good.
module imem_loader #(
    parameter int          DEPTH      = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    imem_loader_if.master          bus,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error,
    output logic [$clog2(DEPTH):0] words_loaded
);

    localparam int WLW = $clog2(DEPTH) + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] CSUM  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERROR = 3'd5;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [7:0]  csum;
    logic [31:0] word_asm;

    logic        accept;
    logic        last_byte;
    logic        last_word;
    logic [31:0] len_next;
    logic [31:0] word_next;
    logic [31:0] addr_calc;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign len_next  = {len[23:0], bus.rx_data};
    assign word_next = BIG_ENDIAN ? {word_asm[23:0], bus.rx_data}
                                  : {bus.rx_data, word_asm[31:8]};
    assign last_word = ((32'(words_loaded) + 32'd1) == len);
    assign addr_calc = BASE_ADDR + (32'(words_loaded) << 2);

    // Frame sequencing; start is only honoured in the resting states.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) next_state = LEN;
            end
            LEN: begin
                if (accept && last_byte) begin
                    if (len_next > 32'(DEPTH))  next_state = ERROR;
                    else if (len_next == 32'd0) next_state = CSUM;
                    else                        next_state = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte && last_word) next_state = CSUM;
            end
            CSUM: begin
                if (accept) next_state = (bus.rx_data == csum) ? DONE : ERROR;
            end
            default: next_state = IDLE;
        endcase
    end

    // rx_ready is registered from the next state so it is glitch-free and
    // stays high through the write cycle, allowing back-to-back bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus.rx_ready <= 1'b0;
            bus.we       <= 1'b0;
            bus.wa       <= BASE_ADDR;
            bus.wd       <= 32'd0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            len          <= 32'd0;
            csum         <= 8'd0;
            word_asm     <= 32'd0;
        end else begin
            state        <= next_state;
            bus.rx_ready <= (next_state == LEN) || (next_state == DATA) ||
                            (next_state == CSUM);
            bus.we       <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        byte_cnt     <= 2'd0;
                        len          <= 32'd0;
                        csum         <= 8'd0;
                        word_asm     <= 32'd0;
                        words_loaded <= '0;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_reset    <= 1'b1;
                    end
                end
                LEN: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        len      <= len_next;
                        csum     <= csum ^ bus.rx_data;
                        if (last_byte && (len_next > 32'(DEPTH))) error <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum ^ bus.rx_data;
                        word_asm <= word_next;
                        // wa uses the count before this word is added.
                        if (last_byte) begin
                            bus.we       <= 1'b1;
                            bus.wd       <= word_next;
                            bus.wa       <= {1'b0, addr_calc[30:0]};
                            words_loaded <= words_loaded + WLW'(1);
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (bus.rx_data == csum) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            error     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a big-endian and a little-endian loader
// receive the same byte stream and are compared against a frame-level model.
module tb_imem_loader;

    localparam int          DEPTH   = 256;
    localparam logic [31:0] BASE_BE = 32'h0000_0000;
    localparam logic [31:0] BASE_LE = 32'h0000_1000;
    localparam int          WLW     = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           cpu_reset_be, done_be, error_be;
    logic           cpu_reset_le, done_le, error_le;
    logic [WLW-1:0] words_be, words_le;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame[$];

    imem_loader_if bus_be ();
    imem_loader_if bus_le ();

    assign bus_be.rx_data  = rx_data;
    assign bus_be.rx_valid = rx_valid;
    assign bus_le.rx_data  = rx_data;
    assign bus_le.rx_valid = rx_valid;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_BE), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .start(start), .bus(bus_be),
        .cpu_reset(cpu_reset_be), .done(done_be), .error(error_be),
        .words_loaded(words_be)
    );

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_LE), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .start(start), .bus(bus_le),
        .cpu_reset(cpu_reset_le), .done(done_le), .error(error_le),
        .words_loaded(words_le)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frameLen();
        return {frame[0], frame[1], frame[2], frame[3]};
    endfunction

    function automatic logic [31:0] modelWord(input int w, input bit big);
        logic [7:0] b0, b1, b2, b3;
        b0 = frame[4 + 4*w];
        b1 = frame[5 + 4*w];
        b2 = frame[6 + 4*w];
        b3 = frame[7 + 4*w];
        return big ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    task automatic buildFrame(input int n, input bit bad);
        logic [7:0]  x;
        logic [31:0] nl;
        nl = n;
        frame.delete();
        frame.push_back(nl[31:24]);
        frame.push_back(nl[23:16]);
        frame.push_back(nl[15:8]);
        frame.push_back(nl[7:0]);
        for (int i = 0; i < 4*n; i++) frame.push_back(8'($urandom));
        x = 8'd0;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(bad ? (x ^ 8'h5A) : x);
    endtask

    task automatic setFrame(input logic [7:0] bytes[$]);
        frame = bytes;
    endtask

    task automatic doStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_done_clr", {done_be, done_le}, 2'b00);
        checkOutput("start_err_clr", {error_be, error_le}, 2'b00);
        checkOutput("start_cpu_rst", {cpu_reset_be, cpu_reset_le}, 2'b11);
        checkOutput("start_words_clr", {words_be, words_le}, '0);
        checkOutput("start_ready", {bus_be.rx_ready, bus_le.rx_ready}, 2'b11);
    endtask

    // Sends the frame (up to max_bytes accepted bytes) with random rx_valid gaps,
    // checking every cycle that a write appears exactly after a word's last byte.
    task automatic applyStimulus(input int gap_pct, input int max_bytes);
        int          nacc = 0;
        int          budget = 0;
        int          limit;
        int          n;
        int          w;
        bit          ovf;
        bit          will;
        bit          exp_we;
        logic [31:0] nl;
        nl    = frameLen();
        ovf   = (nl > 32'(DEPTH));
        n     = ovf ? 0 : int'(nl);
        limit = ovf ? 4 : frame.size();
        if (max_bytes < limit) limit = max_bytes;
        while (nacc < limit && budget < 4000) begin
            rx_valid = ($urandom_range(99) >= gap_pct);
            rx_data  = rx_valid ? frame[nacc] : 8'($urandom);
            #1;
            will = rx_valid && bus_be.rx_ready;
            @(negedge clk);
            exp_we = will && (nacc >= 4) && (nacc < 4 + 4*n) && (((nacc - 4) % 4) == 3);
            checkOutput("we_be", bus_be.we, exp_we);
            checkOutput("we_le", bus_le.we, exp_we);
            if (exp_we) begin
                w = (nacc - 4) / 4;
                checkOutput("wa_be", bus_be.wa, BASE_BE + 32'(4*w));
                checkOutput("wd_be", bus_be.wd, modelWord(w, 1'b1));
                checkOutput("wa_le", bus_le.wa, BASE_LE + 32'(4*w));
                checkOutput("wd_le", bus_le.wd, modelWord(w, 1'b0));
            end
            if (will) nacc++;
            budget++;
        end
        rx_valid = 1'b0;
        if (budget >= 4000) checkOutput("accept_timeout", nacc, limit);
    endtask

    // Final status from the frame rules: length bound, then XOR checksum.
    task automatic checkFinal(input string tag);
        logic [31:0] nl;
        logic [7:0]  x;
        bit          good;
        int          n;
        nl = frameLen();
        if (nl > 32'(DEPTH)) begin
            good = 1'b0;
            n    = 0;
        end else begin
            n = int'(nl);
            x = 8'd0;
            for (int i = 0; i < 4 + 4*n; i++) x = x ^ frame[i];
            good = (frame[4 + 4*n] == x);
        end
        checkOutput({tag, "_done"}, {done_be, done_le}, {good, good});
        checkOutput({tag, "_error"}, {error_be, error_le}, {!good, !good});
        checkOutput({tag, "_cpu_reset"}, {cpu_reset_be, cpu_reset_le}, {!good, !good});
        checkOutput({tag, "_words"}, {words_be, words_le}, {WLW'(n), WLW'(n)});
        @(negedge clk);
        checkOutput({tag, "_ready_low"}, {bus_be.rx_ready, bus_le.rx_ready}, 2'b00);
        checkOutput({tag, "_we_low"}, {bus_be.we, bus_le.we}, 2'b00);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpu_reset"}, {cpu_reset_be, cpu_reset_le}, 2'b11);
        checkOutput({tag, "_ready"}, {bus_be.rx_ready, bus_le.rx_ready}, 2'b00);
        checkOutput({tag, "_we"}, {bus_be.we, bus_le.we}, 2'b00);
        checkOutput({tag, "_done"}, {done_be, done_le}, 2'b00);
        checkOutput({tag, "_error"}, {error_be, error_le}, 2'b00);
        checkOutput({tag, "_words"}, {words_be, words_le}, '0);
        checkOutput({tag, "_wa_be"}, bus_be.wa, BASE_BE);
        checkOutput({tag, "_wa_le"}, bus_le.wa, BASE_LE);
        checkOutput({tag, "_wd"}, {bus_be.wd, bus_le.wd}, 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;

        $display("[TB] good two-word load");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h23, 8'h45, 8'h67, 8'h20});
        applyStimulus(0, 1 << 20);
        checkFinal("good2");
        checkOutput("good2_last_wd_be", bus_be.wd, 32'h0123_4567);

        $display("[TB] bad checksum");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h23, 8'h45, 8'h67, 8'h21});
        applyStimulus(0, 1 << 20);
        checkFinal("badcs");

        $display("[TB] length overflow");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h01, 8'h01, 8'h11, 8'h22});
        applyStimulus(0, 1 << 20);
        checkOutput("ovf_error_next", {error_be, error_le}, 2'b11);
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        repeat (4) begin
            @(negedge clk);
            checkOutput("ovf_no_ready", {bus_be.rx_ready, bus_le.rx_ready}, 2'b00);
            checkOutput("ovf_no_we", {bus_be.we, bus_le.we}, 2'b00);
        end
        rx_valid = 1'b0;
        checkFinal("ovf");

        $display("[TB] empty image and single little-endian word");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        applyStimulus(0, 1 << 20);
        checkFinal("empty");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23});
        applyStimulus(0, 1 << 20);
        checkOutput("le_word", bus_le.wd, 32'hEFBE_ADDE);
        checkOutput("be_word", bus_be.wd, 32'hDEAD_BEEF);
        checkFinal("one");

        $display("[TB] full-depth image");
        doStart();
        buildFrame(DEPTH, 1'b0);
        applyStimulus(0, 1 << 20);
        checkFinal("full");

        $display("[TB] random gaps and random frames");
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h23, 8'h45, 8'h67, 8'h20});
        applyStimulus(40, 1 << 20);
        checkFinal("gaps");
        for (int t = 0; t < 10; t++) begin
            doStart();
            buildFrame(int'($urandom_range(0, 8)), ($urandom_range(3) == 0));
            applyStimulus(int'($urandom_range(0, 60)), 1 << 20);
            checkFinal("rand");
        end

        $display("[TB] reset mid-load");
        doStart();
        buildFrame(2, 1'b0);
        applyStimulus(30, 6);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("abort");
        @(negedge clk);
        reset = 1'b0;
        doStart();
        setFrame('{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h01, 8'h23, 8'h45, 8'h67, 8'h20});
        applyStimulus(0, 1 << 20);
        checkFinal("reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
